spi_phase_sequencer: RTL

SPI_PHASE_SEQUENCER -- requirements
Module: spi_phase_sequencer

---
 rtl/spi_seq_pkg.sv | 28 ++
 rtl/phase_timer.sv | 22 ++
 rtl/spi_phase_sequencer.sv | 118 +++++++++++
 3 files changed

// File: rtl/spi_seq_pkg.sv
// spi_seq_pkg: shared state encoding, default phase lengths and width helpers
// for the SPI phase sequencer.
package spi_seq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    AMP  = 2'd1,
    ADC  = 2'd2,
    DAC  = 2'd3
  } state_e;

  localparam int DEF_AMP_CYCLES = 10;
  localparam int DEF_ADC_CYCLES = 35;
  localparam int DEF_DAC_CYCLES = 33;
  localparam int DEF_NUM_CH     = 2;

  // Index width for n items, never narrower than one bit.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/phase_timer.sv
// phase_timer: loadable down-counter that parks at zero and flags it.
module phase_timer #(
  parameter int W = 6
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  output logic         zero_o
);

  logic [W-1:0] count_q;

  always_ff @(negedge clk_i or negedge rst_ni) begin
    if (!rst_ni)      count_q <= '0;
    else if (load_i)  count_q <= load_val_i;
    else if (!zero_o) count_q <= count_q - 1'b1;
  end

  assign zero_o = (count_q == '0);

endmodule

// File: rtl/spi_phase_sequencer.sv
// spi_phase_sequencer: sequences AMP -> ADC -> DAC enable phases on the falling
// clock edge, with gain re-configuration, graceful stop and round-robin DAC channel.
module spi_phase_sequencer
  import spi_seq_pkg::*;
#(
  parameter int AMP_CYCLES = DEF_AMP_CYCLES,
  parameter int ADC_CYCLES = DEF_ADC_CYCLES,
  parameter int DAC_CYCLES = DEF_DAC_CYCLES,
  parameter int NUM_CH     = DEF_NUM_CH
) (
  input  logic                         clock,
  input  logic                         reset_n,
  input  logic                         start,
  input  logic                         continuous,
  input  logic                         stop,
  input  logic                         regain_req,
  output logic                         enable_amp,
  output logic                         enable_adc,
  output logic                         enable_dac,
  output logic [idx_width(NUM_CH)-1:0] dac_channel,
  output logic                         busy,
  output logic                         frame_done,
  output logic                         spi_ss_b,
  output logic                         sf_ce0,
  output logic                         fpga_init_b
);

  localparam int CH_W = idx_width(NUM_CH);
  localparam int CW   = idx_width(max3(AMP_CYCLES, ADC_CYCLES, DAC_CYCLES));

  localparam logic [CW-1:0]   AMP_LEN = CW'(AMP_CYCLES - 1);
  localparam logic [CW-1:0]   ADC_LEN = CW'(ADC_CYCLES - 1);
  localparam logic [CW-1:0]   DAC_LEN = CW'(DAC_CYCLES - 1);
  localparam logic [CH_W-1:0] CH_LAST = CH_W'(NUM_CH - 1);

  state_e          state_q, state_d;
  logic            gain_ok_q, gain_ok_d;
  logic            stop_q, stop_d;
  logic            regain_q, regain_d;
  logic [CH_W-1:0] ch_q, ch_d;
  logic            load;
  logic [CW-1:0]   load_val;
  logic            zero;
  logic            regain_eff;
  logic            dac_done;

  phase_timer #(.W(CW)) u_timer (
    .clk_i      (clock),
    .rst_ni     (reset_n),
    .load_i     (load),
    .load_val_i (load_val),
    .zero_o     (zero)
  );

  always_ff @(negedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      gain_ok_q <= 1'b0;
      stop_q    <= 1'b0;
      regain_q  <= 1'b0;
      ch_q      <= '0;
    end else begin
      state_q   <= state_d;
      gain_ok_q <= gain_ok_d;
      stop_q    <= stop_d;
      regain_q  <= regain_d;
      ch_q      <= ch_d;
    end
  end

  // A request arriving on the deciding cycle counts as already pending.
  assign regain_eff = regain_q | regain_req;
  assign dac_done   = (state_q == DAC) && zero;

  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    unique case (state_q)
      IDLE: if (start) begin
        load    = 1'b1;
        state_d = (!gain_ok_q || regain_eff) ? AMP : ADC;
      end
      AMP: if (zero) begin
        load    = 1'b1;
        state_d = ADC;
      end
      ADC: if (zero) begin
        load    = 1'b1;
        state_d = DAC;
      end
      DAC: if (zero) begin
        load    = 1'b1;
        state_d = (continuous && !(stop_q || stop)) ? (regain_eff ? AMP : ADC) : IDLE;
      end
      default: state_d = IDLE;
    endcase
    load_val  = (state_d == AMP) ? AMP_LEN :
                (state_d == ADC) ? ADC_LEN :
                (state_d == DAC) ? DAC_LEN : '0;
    gain_ok_d = gain_ok_q | ((state_q == AMP) && zero);
    // Stop in IDLE only counts when it arrives together with start.
    stop_d    = dac_done ? 1'b0 : (stop_q | (stop && ((state_q != IDLE) || start)));
    regain_d  = ((state_d == AMP) && (state_q != AMP)) ? 1'b0 :
                (regain_q | (regain_req && (state_q != AMP)));
    ch_d      = dac_done ? ((ch_q == CH_LAST) ? '0 : ch_q + 1'b1) : ch_q;
  end

  assign enable_amp  = (state_q == AMP);
  assign enable_adc  = (state_q == ADC);
  assign enable_dac  = (state_q == DAC);
  assign busy        = (state_q != IDLE);
  assign frame_done  = dac_done;
  assign dac_channel = ch_q;
  assign spi_ss_b    = 1'b1;
  assign sf_ce0      = 1'b1;
  assign fpga_init_b = 1'b0;

endmodule
